// File: rtl/picorv32_bus_pkg.sv
// Shared types and helpers for the picorv32-to-Wishbone bridge.
package picorv32_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

  // Reads fetch the whole word; writes select only the strobed bytes.
  function automatic logic [3:0] wstrb_to_sel(input logic [3:0] wstrb);
    return (wstrb == 4'h0) ? 4'hF : wstrb;
  endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// Loadable down-counter that flags expiry one cycle after reaching zero.
// With TIMEOUT_CYCLES == 0 the timer is removed and never expires.
module bus_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_timer;
      assign unused_timer = ^{clk, resetn, clear, en};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] count;
      logic          expired_q;

      // The expiry flag is registered, so the abort lands one cycle after zero.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          count     <= '0;
          expired_q <= 1'b0;
        end else if (clear) begin
          count     <= LOAD;
          expired_q <= 1'b0;
        end else if (en) begin
          if (count != '0) count <= count - CW'(1);
          expired_q <= (count == '0);
        end
      end

      assign expired = expired_q;
    end
  endgenerate

endmodule

// File: rtl/picorv32_wb_bridge.sv
// Registered picorv32 native-memory to Wishbone B4 classic bridge with timeout
// and error capture. Define BRIDGE_ACTIVE_LOW_BUS_EN to invert every wb_* pin.
module picorv32_wb_bridge
  import picorv32_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-3:0] wb_adr,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel,
  output logic                  wb_we,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [7:0]            err_count
);

  bridge_state_t state_q, state_d;

  logic                  cyc_q, stb_q, we_q;
  logic [3:0]            sel_q;
  logic [ADDR_WIDTH-3:0] adr_q;
  logic [31:0]           dat_o_q;

  logic        ack_in, err_in;
  logic [31:0] dat_in;
  logic        expired;

  logic req_accept, rsp_ack, rsp_fail;

  logic unused_addr;
  assign unused_addr = ^mem_addr[1:0];

`ifdef BRIDGE_ACTIVE_LOW_BUS_EN
  assign wb_cyc   = ~cyc_q;
  assign wb_stb   = ~stb_q;
  assign wb_we    = ~we_q;
  assign wb_sel   = ~sel_q;
  assign wb_adr   = ~adr_q;
  assign wb_dat_o = ~dat_o_q;
  assign ack_in   = ~wb_ack;
  assign err_in   = ~wb_err;
  assign dat_in   = ~wb_dat_i;
`else
  assign wb_cyc   = cyc_q;
  assign wb_stb   = stb_q;
  assign wb_we    = we_q;
  assign wb_sel   = sel_q;
  assign wb_adr   = adr_q;
  assign wb_dat_o = dat_o_q;
  assign ack_in   = wb_ack;
  assign err_in   = wb_err;
  assign dat_in   = wb_dat_i;
`endif

  bus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (req_accept),
    .en     (state_q == ST_WAIT),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_valid) state_d = ST_WAIT;
      ST_WAIT: if (ack_in || err_in || expired) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; ack wins over err and timeout, and responses count only in WAIT.
  always_comb begin
    req_accept = (state_q == ST_IDLE) && mem_valid;
    rsp_ack    = (state_q == ST_WAIT) && ack_in;
    rsp_fail   = (state_q == ST_WAIT) && !ack_in && (err_in || expired);
  end

  // Bus-side registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      dat_o_q <= '0;
    end else if (req_accept) begin
      cyc_q   <= 1'b1;
      stb_q   <= 1'b1;
      we_q    <= |mem_wstrb;
      sel_q   <= wstrb_to_sel(mem_wstrb);
      adr_q   <= mem_addr[ADDR_WIDTH-1:2];
      dat_o_q <= mem_wdata;
    end else if (rsp_ack || rsp_fail) begin
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
    end
  end

  // Core-side completion and error capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      mem_rdata <= '0;
      err_addr  <= '0;
      err_count <= 8'h00;
    end else begin
      mem_ready <= rsp_ack || rsp_fail;
      bus_err   <= rsp_fail;
      if (rsp_ack) begin
        mem_rdata <= dat_in;
      end else if (rsp_fail) begin
        mem_rdata <= ERR_RDATA;
        err_addr  <= {adr_q, 2'b00};
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Directed and randomized bench for picorv32_wb_bridge against a transaction-level model.
module tb_picorv32_wb_bridge;

  localparam int AW = 32;
  localparam int T  = 8;
  localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_NONE = 3;

`ifdef BRIDGE_ACTIVE_LOW_BUS_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [AW-3:0] wb_adr;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic [31:0]   wb_dat_i;
  logic          wb_ack, wb_err;
  logic          bus_err;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_count;

  logic          ack_l = 1'b0, err_l = 1'b0;
  logic [31:0]   dati_l = '0;

  always #5 clk = ~clk;

  // Logical (active-high) view of the bus pins
  wire          cyc_l  = wb_cyc ^ INV;
  wire          stb_l  = wb_stb ^ INV;
  wire          we_l   = wb_we ^ INV;
  wire [3:0]    sel_l  = wb_sel ^ {4{INV}};
  wire [AW-3:0] adr_l  = wb_adr ^ {(AW-2){INV}};
  wire [31:0]   dato_l = wb_dat_o ^ {32{INV}};
  assign wb_ack   = ack_l ^ INV;
  assign wb_err   = err_l ^ INV;
  assign wb_dat_i = dati_l ^ {32{INV}};

  picorv32_wb_bridge #(
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T), .ERR_RDATA(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int unsigned   m_count = 0;
  logic [AW-1:0] m_err_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int ws, input int resp, input logic [31:0] slv_data);
    int   wait_cycles;
    logic fail;
    logic [31:0] rd_exp;
    // The slave answers on wait cycle ws unless the timeout (T+2 wait cycles) fires first.
    if (resp != R_NONE && ws <= T + 1) begin
      wait_cycles = ws + 1;
      fail = (resp == R_ERR);
    end else begin
      wait_cycles = T + 2;
      fail = 1'b1;
    end
    rd_exp = fail ? 32'hFFFF_FFFF : slv_data;

    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    for (int k = 0; k < wait_cycles; k++) begin
      @(negedge clk);
      chk("cyc", cyc_l, 1'b1);
      chk("stb", stb_l, 1'b1);
      chk("adr", adr_l, addr[31:2]);
      chk("sel", sel_l, (wstrb == 4'h0) ? 4'hF : wstrb);
      chk("we", we_l, wstrb != 4'h0);
      chk("dat_o", dato_l, wdata);
      chk("ready_early", mem_ready, 1'b0);
      ack_l  = (k == ws) && (resp == R_ACK || resp == R_BOTH);
      err_l  = (k == ws) && (resp == R_ERR || resp == R_BOTH);
      dati_l = (k == ws) ? slv_data : ~slv_data;
    end

    if (fail) begin
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_err_addr = {addr[31:2], 2'b00};
    end

    @(negedge clk);
    chk("ready", mem_ready, 1'b1);
    chk("cyc_done", cyc_l, 1'b0);
    chk("rdata", mem_rdata, rd_exp);
    chk("bus_err", bus_err, fail);
    chk("err_count", err_count, m_count);
    chk("err_addr", err_addr, m_err_addr);
    // Stray responses outside WAIT must be ignored; mem_valid is still high here.
    ack_l = 1'($urandom_range(0, 1));
    err_l = 1'($urandom_range(0, 1));

    @(negedge clk);
    chk("ready_pulse", mem_ready, 1'b0);
    chk("no_reissue", cyc_l, 1'b0);
    chk("bus_err_pulse", bus_err, 1'b0);
    chk("err_count_hold", err_count, m_count);
    mem_valid = 1'b0; ack_l = 1'b0; err_l = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cyc", wb_cyc, INV);
    chk("rst_stb", wb_stb, INV);
    chk("rst_we", wb_we, INV);
    chk("rst_sel", wb_sel, {4{INV}});
    chk("rst_adr", wb_adr, {(AW-2){INV}});
    chk("rst_dat_o", wb_dat_o, {32{INV}});
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_count", err_count, 8'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Zero-wait read, write with wait states, timeout, simultaneous ack+err
    xfer(32'h0000_0104, 32'h0, 4'h0, 0, R_ACK, 32'hDEAD_BEEF);
    chk("read_adr_word", mem_addr[31:2], 30'h41);
    xfer(32'h0000_0200, 32'h1234_5678, 4'b0011, 5, R_ACK, 32'hCAFE_0001);
    xfer(32'h0000_0300, 32'h0, 4'h0, 0, R_NONE, 32'h5555_AAAA);
    xfer(32'h0000_0400, 32'h0, 4'h0, 2, R_BOTH, 32'h0BAD_F00D);

    // Stray response while idle
    @(negedge clk);
    ack_l = 1'b1; err_l = 1'b1;
    @(negedge clk);
    chk("idle_ready", mem_ready, 1'b0);
    chk("idle_cyc", cyc_l, 1'b0);
    chk("idle_bus_err", bus_err, 1'b0);
    chk("idle_err_count", err_count, m_count);
    ack_l = 1'b0; err_l = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 40; i++)
      xfer($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 11),
           $urandom_range(0, 3), $urandom);

    // Saturate the error counter
    for (int i = 0; i < 300; i++)
      xfer($urandom, $urandom, 4'($urandom_range(0, 15)), 0, R_ERR, $urandom);
    chk("err_count_sat", err_count, 8'hFF);

    // Reset during WAIT: cyc drops at once and no completion reaches the core
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0800; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("pre_rst_cyc", cyc_l, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("async_rst_cyc", cyc_l, 1'b0);
    chk("async_rst_ready", mem_ready, 1'b0);
    chk("async_rst_count", err_count, 8'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    resetn = 1'b1;
    m_count = 0;
    m_err_addr = '0;
    @(negedge clk);
    chk("post_rst_ready", mem_ready, 1'b0);
    chk("post_rst_cyc", cyc_l, 1'b0);
    xfer(32'h0000_0104, 32'h0, 4'h0, 0, R_ACK, 32'hDEAD_BEEF);
    xfer(32'h0000_0C00, 32'h0, 4'hF, 1, R_ERR, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/picorv32_wb_bridge.md
# picorv32_wb_bridge

Registered bridge between the picorv32 native memory interface and a Wishbone B4 classic bus, with transaction timeout, bus-error capture and a compile-time option for active-low bus signalling. It replaces the combinational glue between the core and the bus. The core side connects directly to picorv32 `mem_*` ports; the bus side drives the memory/peripheral interconnect.

## Interface
- `ADDR_WIDTH`, 32: core address width. The bus address is `[ADDR_WIDTH-1:2]`.
- `TIMEOUT_CYCLES`, 255: number of WAIT cycles before a transfer is aborted. 0 disables the timeout.
- `ERR_RDATA`, 32'hFFFF_FFFF: read data returned to the core on an error or timeout.

Ports (clock and reset first):
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: core request.
- `mem_addr` in ADDR_WIDTH: byte address. Bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write strobes. 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: registered read data, valid while `mem_ready` is high.
- `wb_adr` out ADDR_WIDTH-2: word address.
- `wb_dat_o` out 32: write data.
- `wb_sel` out 4: byte select. Equals `mem_wstrb` on writes and 4'hF on reads.
- `wb_we` out 1: write enable. Equals the OR of `mem_wstrb`.
- `wb_cyc` out 1: bus cycle.
- `wb_stb` out 1: strobe.
- `wb_dat_i` in 32: read data.
- `wb_ack` in 1: slave acknowledge.
- `wb_err` in 1: slave error.
- `bus_err` out 1: one-cycle pulse on an error or timeout.
- `err_addr` out ADDR_WIDTH: byte address of the last failed transfer.
- `err_count` out 8: saturating count of failed transfers.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - When `mem_valid` is high, latch address, wdata, sel and we into the bus registers.
  - Assert `wb_cyc` and `wb_stb`, then go to WAIT.
- WAIT:
  - Hold all bus outputs stable.
  - On `wb_ack` (priority over `wb_err`): capture `wb_dat_i` into `mem_rdata`, drop cyc/stb, go to DONE.
  - On `wb_err`: load `ERR_RDATA` into `mem_rdata`, pulse `bus_err`, latch `err_addr`, increment `err_count` (saturates at 255), drop cyc/stb, go to DONE.
  - Timeout: the timeout counter counts cycles spent in WAIT. When it reaches `TIMEOUT_CYCLES` with no ack or err, handle it exactly as `wb_err`.
  - The timeout counter clears on entry to WAIT.
- DONE:
  - `mem_ready` is high for exactly this cycle, then go to IDLE.
  - `mem_valid` is not sampled in DONE, so one request can never issue twice.
- Write transfers still update `mem_rdata` (with `wb_dat_i` or `ERR_RDATA`). The core ignores it.
- Ack and err in the same cycle count as ack.
- Ack or err arriving outside WAIT is ignored.
- `mem_instr` is not used.

## Timing
- Reset (asynchronous assert, synchronous-release safe): state IDLE.
- Reset values of outputs:
  - `mem_ready`, `bus_err`, `wb_cyc`, `wb_stb`, `wb_we` are 0.
  - `wb_adr`, `wb_dat_o`, `wb_sel`, `mem_rdata`, `err_addr`, `err_count` are 0.
- Reset mid-transfer drops `wb_cyc` immediately, with no completion to the core.
- All outputs are registered. There are no combinational paths from core to bus or bus to core.
- Latency:
  - `mem_valid` sampled at edge N gives `wb_cyc` high from N+1.
  - Ack seen at edge M gives `mem_ready` high in cycle M+1.
  - Zero-wait-state slave: 3 cycles from request to ready.
- A timeout with `TIMEOUT_CYCLES`=T gives `mem_ready` T+2 cycles after `wb_cyc` rises.

## Configuration
- `BRIDGE_ACTIVE_LOW_BUS_EN`:
  - Defined: every `wb_*` port is active-low/inverted at the pin (`wb_cyc`, `wb_stb`, `wb_we`, `wb_sel`, `wb_adr`, `wb_dat_o`, `wb_dat_i`, `wb_ack`, `wb_err`). Bus output reset values become all-ones.
  - Undefined: bus ports are active-high.
- Core-side ports and `bus_err`/`err_*` are never inverted.

## Structure
- Package `picorv32_bus_pkg`:
  - FSM state enum.
  - Default `ERR_RDATA` constant.
  - Function `wstrb_to_sel`.
- Sub-module `bus_timeout_timer`:
  - Loadable down-counter with clear and expiry flag.
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Tied off when `TIMEOUT_CYCLES`=0.

## Test plan
- Read at 0x0000_0104, slave acks on first WAIT cycle with 0xDEAD_BEEF -> `wb_adr`=0x41, `wb_sel`=F, `wb_we`=0; `mem_ready` is one cycle at request+3 with `mem_rdata`=0xDEAD_BEEF.
- Write 0x1234_5678 with wstrb 4'b0011 at 0x200, slave acks after 5 wait states -> `wb_we`=1, `wb_sel`=3, bus outputs stable throughout, `mem_ready` once.
- No ack, `TIMEOUT_CYCLES`=8 -> `mem_ready` 10 cycles after `wb_cyc` rises with `mem_rdata`=0xFFFF_FFFF, `bus_err` pulse, `err_addr` = request address, `err_count`=1.
- `wb_ack` and `wb_err` asserted together -> treated as ack, no `bus_err`, `err_count` unchanged; 300 forced errors -> `err_count` holds 255.
- `resetn` low during WAIT -> `wb_cyc`=0 asynchronously, no `mem_ready`; next request after reset completes normally.
- Build with `BRIDGE_ACTIVE_LOW_BUS_EN`, repeat scenario 1 with an inverted slave model -> identical core-side results, bus outputs all-ones in reset.
